// File: rtl/imem_loader.sv
// imem_loader: accepts a length-prefixed, little-endian byte stream and writes it into instruction memory, holding the core in reset until the image is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte before DONE.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_end_state;
    logic [15:0] r_count;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_asm;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        w_xfer;
    logic [15:0] w_len;
    logic [15:0] w_word_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    assign w_xfer     = byte_valid && byte_ready;
    assign w_len      = {byte_data, r_count[7:0]};
    assign w_word_inc = r_word_idx + 16'd1;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_end_state = CHK;
`else
    assign w_end_state = DONE;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LEN0: if (w_xfer) w_next = LEN1;
            LEN1: begin
                if (w_xfer) begin
                    if (32'(w_len) > DEPTH_WORDS) begin
                        w_next = ERR;
                    end else if (w_len == 16'd0) begin
                        w_next = w_end_state;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA:  if (w_xfer && r_byte_idx == 2'd3) w_next = WRITE;
            WRITE: w_next = (w_word_inc == r_count) ? w_end_state : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:   if (w_xfer) w_next = (byte_data == r_sum) ? DONE : ERR;
`endif
            DONE:  w_next = DONE;
            ERR:   w_next = ERR;
            default: w_next = LEN0;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            LEN0, LEN1, DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:   byte_ready = 1'b1;
`endif
            WRITE: wr_en = 1'b1;
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // Output word and address are captured with the 4th byte so they are ready in WRITE and hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= '0;
        end else begin
            if (w_xfer) begin
                case (r_state)
                    LEN0: r_count[7:0]  <= byte_data;
                    LEN1: r_count[15:8] <= byte_data;
                    DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= byte_data;
                            2'd1: r_asm[15:8]  <= byte_data;
                            2'd2: r_asm[23:16] <= byte_data;
                            default: begin
                                r_wr_data <= {byte_data, r_asm};
                                r_wr_addr <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (r_state == WRITE) begin
                r_word_idx <= w_word_inc;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_xfer && r_state != CHK) begin
            r_sum <= r_sum + byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven stream vectors for imem_loader plus hand-written reset-during-load sequences.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    localparam logic [31:0] BASE = 32'h0000_0000;

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        string       name;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          nsend;
        logic [31:0] seed;
        bit          gap;
        bit          corrupt;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          total = 0;
    int          bad = 0;
    int          busy_accept = 0;
    int          both_flags = 0;
    int          early_release = 0;
    logic [7:0]  sum;

    // Write monitor and invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            if (byte_ready) busy_accept++;
        end
        if (done && error) both_flags++;
        if (!cpu_reset && !done) early_release++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
        return seed + 32'(i) * 32'h0010_0080;
    endfunction

    task automatic apply_reset();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reset      = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        wq_addr.delete();
        wq_data.delete();
        busy_accept   = 0;
        early_release = 0;
        sum           = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " byte_ready"}, 32'(byte_ready), 32'd1);
        check({tag, " wr_en"},      32'(wr_en),      32'd0);
        check({tag, " wr_addr"},    wr_addr,         BASE);
        check({tag, " wr_data"},    wr_data,         32'd0);
        check({tag, " cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, " done"},       32'(done),       32'd0);
        check({tag, " error"},      32'(error),      32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte_ready=0 after 50 cycles, required 1");
        end
        @(posedge clk);
        #1;
        sum = sum + b;
    endtask

    task automatic send_stream(input logic [7:0] lo, input logic [7:0] hi, input int n,
                               input logic [31:0] seed, input bit gap, input bit with_chk,
                               input bit corrupt);
        logic [31:0] w;
        logic [7:0]  ck;
        send_byte(lo, gap);
        send_byte(hi, gap);
        for (int i = 0; i < n; i++) begin
            w = word_of(seed, i);
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (with_chk) begin
            ck = sum + 8'(corrupt);
            send_byte(ck, gap);
        end
`else
        ck = 8'(with_chk) & 8'(corrupt);
        if (ck != 8'h00) $display("note: checksum byte not used in this build");
`endif
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        while (!done && !error && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!done && !error) begin
            total++;
            bad++;
            $display("FAIL %s end_timeout: done=0 error=0 after 20 cycles, required one set", tag);
        end
        // Extra bytes offered after the end must be ignored.
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [31:0] seed);
        check({tag, " nwrites"}, 32'(wq_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            check({tag, $sformatf(" addr[%0d]", i)}, wq_addr[i], BASE + 32'(4 * i));
            check({tag, $sformatf(" data[%0d]", i)}, wq_data[i], word_of(seed, i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"n2_held",    8'h02, 8'h00, 2,   32'h00A0_0513, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"n2_toggle",  8'h02, 8'h00, 2,   32'h00A0_0513, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"n257",       8'h01, 8'h01, 0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"n0",         8'h00, 8'h00, 0,   32'h0,         1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"n1_toggle",  8'h01, 8'h00, 1,   32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"nffff",      8'hFF, 8'hFF, 0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"n256_max",   8'h00, 8'h01, 256, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"n3",         8'h03, 8'h00, 3,   32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{"n2_badsum",  8'h02, 8'h00, 2,   32'h00A0_0513, 1'b0, 1'b1, 1'b0, 1'b1});
`endif

        apply_reset();
        check_reset_outputs("por");

        foreach (vecs[v]) begin
            apply_reset();
            send_stream(vecs[v].lo, vecs[v].hi, vecs[v].nsend, vecs[v].seed, vecs[v].gap,
                        vecs[v].exp_done || vecs[v].corrupt, vecs[v].corrupt);
            wait_end(vecs[v].name);
            check({vecs[v].name, " done"},       32'(done),       32'(vecs[v].exp_done));
            check({vecs[v].name, " error"},      32'(error),      32'(vecs[v].exp_err));
            check({vecs[v].name, " cpu_reset"},  32'(cpu_reset),  32'(!vecs[v].exp_done));
            check({vecs[v].name, " byte_ready"}, 32'(byte_ready), 32'd0);
            check({vecs[v].name, " ready_in_write"}, 32'(busy_accept), 32'd0);
            check({vecs[v].name, " early_release"},  32'(early_release), 32'd0);
            check_writes(vecs[v].name, vecs[v].nsend, vecs[v].seed);
            if (vecs[v].nsend > 0) begin
                check({vecs[v].name, " addr_hold"}, wr_addr, BASE + 32'(4 * (vecs[v].nsend - 1)));
                check({vecs[v].name, " data_hold"}, wr_data, word_of(vecs[v].seed, vecs[v].nsend - 1));
            end
        end

        // Reset mid-word: two data bytes of word 0 accepted, then reset.
        apply_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midword");
        apply_reset();
        send_stream(8'h02, 8'h00, 2, 32'h00A0_0513, 1'b0, 1'b1, 1'b0);
        wait_end("midword_reload");
        check("midword_reload done", 32'(done), 32'd1);
        check_writes("midword_reload", 2, 32'h00A0_0513);

        // Reset asserted while WRITE is active kills the strobe at once.
        apply_reset();
        send_stream(8'h01, 8'h00, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        check("inwrite wr_en_before", 32'(wr_en), 32'd1);
        check("inwrite wr_data_before", wr_data, 32'hCAFE_F00D);
        reset = 1'b1;
        #1;
        check_reset_outputs("inwrite");
        @(negedge clk);
        #1;
        check("inwrite no_write", 32'(wq_addr.size()), 32'd0);
        reset = 1'b0;

        check("never_done_and_error", 32'(both_flags), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
